// File: rtl/apb_sensor_completer.sv
// APB completer bridging a bus master to a sensor acquisition core: command
// hand-off, result capture with ready/overrun tracking, and programmable wait states.
module apb_sensor_completer #(
  parameter int unsigned WAIT_CYCLES = 1
) (
  input  logic        Clk,
  input  logic        Rst_n,
  input  logic        PSEL,
  input  logic        PENABLE,
  input  logic        PWRITE,
  input  logic [3:0]  PADDR,
  input  logic [31:0] PWDATA,
  output logic [31:0] PRDATA,
  output logic        PREADY,
  output logic        PSLVERR,
  output logic [31:0] CmdOut,
  output logic        CmdValid,
  input  logic        CmdAccept,
  input  logic [31:0] ResultIn,
  input  logic        ResultValid
);

  localparam int unsigned CntW  = 4;
  localparam int unsigned DataW = 32;

  localparam logic [1:0] IdxCmd    = 2'd0;
  localparam logic [1:0] IdxStatus = 2'd1;
  localparam logic [1:0] IdxResult = 2'd2;
  localparam logic [1:0] IdxCtrl   = 2'd3;

  typedef enum logic [1:0] {IDLE, SETUP, ACCESS} state_e;

  state_e            state_q, state_d, cur_state;
  logic [CntW-1:0]   cnt_q, cnt_d;
  logic [DataW-1:0]  cmd_q, cmd_d, res_q, res_d;
  logic              pend_q, pend_d, valid_q, valid_d;
  logic              rdy_q, rdy_d, ovr_q, ovr_d;

  logic              complete, acc_err, aligned;
  logic [1:0]        idx;
  logic [DataW-1:0]  rdata;
  logic              cmd_wr, ctrl_wr, res_rd, soft_clr, ovr_clr;

  // Any cycle presenting PSEL & !PENABLE is a setup phase, whatever the registered state.
  always_comb begin
    cur_state = state_q;
    if (PSEL && !PENABLE) cur_state = SETUP;
    state_d = cur_state;
    cnt_d   = cnt_q;
    PREADY  = 1'b0;
    case (cur_state)
      IDLE:  state_d = IDLE;
      SETUP: begin
        state_d = ACCESS;
        cnt_d   = CntW'(WAIT_CYCLES);
      end
      ACCESS: begin
        PREADY = (cnt_q == '0);
        if (!PSEL || PREADY) state_d = IDLE;
        else                 cnt_d   = cnt_q - CntW'(1);
      end
      default: state_d = IDLE;
    endcase
  end

  assign complete = PSEL && PENABLE && PREADY;
  assign aligned  = (PADDR[1:0] == 2'b00);
  assign idx      = PADDR[3:2];

  // Access decode: error classification and read mux.
  always_comb begin
    acc_err = 1'b0;
    rdata   = '0;
    if (!aligned) begin
      acc_err = 1'b1;
    end else if (PWRITE) begin
      case (idx)
        IdxCmd:    acc_err = (PWDATA[31:30] == 2'b11) || pend_q;
        IdxStatus: acc_err = 1'b1;
        IdxResult: acc_err = 1'b1;
        default:   acc_err = 1'b0;
      endcase
    end else begin
      case (idx)
        IdxCmd:    rdata = cmd_q;
        IdxStatus: rdata = {29'd0, ovr_q, pend_q, rdy_q};
        IdxResult: rdata = res_q;
        default:   acc_err = 1'b1;
      endcase
    end
  end

  assign PRDATA  = (complete && !acc_err) ? rdata : '0;
  assign PSLVERR = complete && acc_err;

  assign cmd_wr   = complete && !acc_err && PWRITE && (idx == IdxCmd);
  assign ctrl_wr  = complete && !acc_err && PWRITE && (idx == IdxCtrl);
  assign res_rd   = complete && !acc_err && !PWRITE && (idx == IdxResult);
  assign soft_clr = ctrl_wr && PWDATA[1];
  assign ovr_clr  = ctrl_wr && PWDATA[0];

  // Register side effects; a coincident capture beats an overrun clear.
  always_comb begin
    cmd_d   = cmd_q;
    pend_d  = pend_q;
    valid_d = 1'b0;
    res_d   = res_q;
    rdy_d   = rdy_q;
    ovr_d   = ovr_q;
    if (soft_clr) begin
      cmd_d  = '0;
      pend_d = 1'b0;
      res_d  = '0;
      rdy_d  = 1'b0;
      ovr_d  = 1'b0;
    end else begin
      if (cmd_wr) begin
        cmd_d   = PWDATA;
        pend_d  = 1'b1;
        valid_d = 1'b1;
      end else if (CmdAccept) begin
        pend_d = 1'b0;
      end
      if (res_rd)  rdy_d = 1'b0;
      if (ovr_clr) ovr_d = 1'b0;
      if (ResultValid) begin
        res_d = ResultIn;
        rdy_d = 1'b1;
        if (rdy_q && !res_rd) ovr_d = 1'b1;
      end
    end
  end

  always_ff @(posedge Clk or negedge Rst_n) begin
    if (!Rst_n) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      cmd_q   <= '0;
      pend_q  <= 1'b0;
      valid_q <= 1'b0;
      res_q   <= '0;
      rdy_q   <= 1'b0;
      ovr_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      cmd_q   <= cmd_d;
      pend_q  <= pend_d;
      valid_q <= valid_d;
      res_q   <= res_d;
      rdy_q   <= rdy_d;
      ovr_q   <= ovr_d;
    end
  end

  assign CmdOut   = cmd_q;
  assign CmdValid = valid_q;

endmodule

// File: tb/tb_apb_sensor_completer.sv
// Bench for apb_sensor_completer: two instances (1 and 0 wait states) on a shared
// bus, directed scenarios plus random traffic against a transaction-level model.
module tb_apb_sensor_completer;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst_n, psel, penable, pwrite, cmd_accept, result_valid;
  logic [3:0]  paddr;
  logic [31:0] pwdata, result_in;

  logic [31:0] prdata1, cmdout1, prdata0, cmdout0;
  logic        pready1, pslverr1, cmdvalid1, pready0, pslverr0, cmdvalid0;

  apb_sensor_completer #(.WAIT_CYCLES(1)) u_w1 (
    .Clk(clk), .Rst_n(rst_n), .PSEL(psel), .PENABLE(penable), .PWRITE(pwrite),
    .PADDR(paddr), .PWDATA(pwdata), .PRDATA(prdata1), .PREADY(pready1),
    .PSLVERR(pslverr1), .CmdOut(cmdout1), .CmdValid(cmdvalid1),
    .CmdAccept(cmd_accept), .ResultIn(result_in), .ResultValid(result_valid));

  apb_sensor_completer #(.WAIT_CYCLES(0)) u_w0 (
    .Clk(clk), .Rst_n(rst_n), .PSEL(psel), .PENABLE(penable), .PWRITE(pwrite),
    .PADDR(paddr), .PWDATA(pwdata), .PRDATA(prdata0), .PREADY(pready0),
    .PSLVERR(pslverr0), .CmdOut(cmdout0), .CmdValid(cmdvalid0),
    .CmdAccept(cmd_accept), .ResultIn(result_in), .ResultValid(result_valid));

  bit          wsel = 1'b1;
  logic [31:0] prdata, cmdout;
  logic        pready, pslverr, cmdvalid;
  assign prdata   = wsel ? prdata1   : prdata0;
  assign cmdout   = wsel ? cmdout1   : cmdout0;
  assign pready   = wsel ? pready1   : pready0;
  assign pslverr  = wsel ? pslverr1  : pslverr0;
  assign cmdvalid = wsel ? cmdvalid1 : cmdvalid0;

  int n_chk  = 0;
  int n_pass = 0;
  int cv_pulses = 0;
  int cv_base;

  always @(negedge clk) if (cmdvalid === 1'b1) cv_pulses++;

  // Reference model state
  logic [31:0] m_cmd, m_res;
  bit          m_pend, m_rdy, m_ovr;
  int          m_writes;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s: observed 0x%08h expected 0x%08h", tag, obs, exp);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic model_reset();
    m_cmd = '0; m_res = '0; m_pend = 0; m_rdy = 0; m_ovr = 0; m_writes = 0;
  endtask

  task automatic model_rv(input logic [31:0] w);
    if (m_rdy) m_ovr = 1;
    m_res = w;
    m_rdy = 1;
  endtask

  // One completed APB transfer, with optional coincident capture / accept.
  task automatic model_apb(input bit wr, input logic [3:0] a, input logic [31:0] d,
                           input bit rv, input logic [31:0] rvw, input bit acc,
                           output logic [31:0] erd, output logic eerr);
    logic [31:0] status;
    bit pend0;
    status = {29'd0, m_ovr, m_pend, m_rdy};
    pend0  = m_pend;
    erd = '0;
    eerr = 0;
    if (acc) m_pend = 0;
    if (a[1:0] != 2'b00) eerr = 1;
    else if (wr) begin
      case (a)
        4'h0: if (d[31:30] == 2'b11 || pend0) eerr = 1;
              else begin m_cmd = d; m_pend = 1; m_writes++; end
        4'h4, 4'h8: eerr = 1;
        default: begin
          if (d[1]) begin
            m_cmd = '0; m_pend = 0; m_res = '0; m_rdy = 0; m_ovr = 0; rv = 0;
          end else if (d[0]) m_ovr = 0;
        end
      endcase
    end else begin
      case (a)
        4'h0: erd = m_cmd;
        4'h4: erd = status;
        4'h8: begin erd = m_res; m_rdy = 0; end
        default: eerr = 1;
      endcase
    end
    if (rv) model_rv(rvw);
  endtask

  // Drives setup + access phases; entered and left at posedge+1.
  task automatic apb(input bit wr, input logic [3:0] a, input logic [31:0] d,
                     input bit rv, input logic [31:0] rvw, input bit acc,
                     output logic [31:0] rd, output logic err, output int cyc);
    bit done = 0;
    rd = '0; err = 0; cyc = 1;
    psel = 1; penable = 0; pwrite = wr; paddr = a; pwdata = d;
    tick();
    penable = 1;
    for (int k = 0; k < 20; k++) begin
      cyc++;
      @(negedge clk);
      if (pready === 1'b1) begin
        rd = prdata;
        err = pslverr;
        if (rv) begin result_valid = 1; result_in = rvw; end
        if (acc) cmd_accept = 1;
        done = 1;
      end
      tick();
      result_valid = 0;
      cmd_accept = 0;
      if (done) break;
    end
    chk("apb_done", 32'(done), 32'd1);
    psel = 0; penable = 0;
  endtask

  task automatic do_apb(input string tag, input bit wr, input logic [3:0] a,
                        input logic [31:0] d, output logic [31:0] rd,
                        input bit rv = 0, input logic [31:0] rvw = 0, input bit acc = 0);
    logic [31:0] erd;
    logic eerr, err;
    int cyc;
    model_apb(wr, a, d, rv, rvw, acc, erd, eerr);
    apb(wr, a, d, rv, rvw, acc, rd, err, cyc);
    chk({tag, "_prdata"}, rd, erd);
    chk({tag, "_pslverr"}, 32'(err), 32'(eerr));
    chk({tag, "_cycles"}, 32'(cyc), wsel ? 32'd3 : 32'd2);
    chk({tag, "_cmdout"}, cmdout, m_cmd);
  endtask

  task automatic pulse_rv(input logic [31:0] w);
    result_valid = 1; result_in = w;
    tick();
    result_valid = 0;
    model_rv(w);
  endtask

  task automatic pulse_accept();
    cmd_accept = 1;
    tick();
    cmd_accept = 0;
    m_pend = 0;
  endtask

  task automatic random_ops(input int n);
    logic [31:0] rd, d;
    logic [3:0] a;
    for (int i = 0; i < n; i++) begin
      case ($urandom_range(0, 4))
        0: pulse_rv($urandom);
        1: pulse_accept();
        default: begin
          case ($urandom_range(0, 4))
            0: a = 4'h0;
            1: a = 4'h4;
            2: a = 4'h8;
            3: a = 4'hC;
            default: a = 4'($urandom);
          endcase
          d = $urandom;
          if (a == 4'hC && $urandom_range(0, 3) != 0) d[1] = 1'b0;
          do_apb("rand", 1'($urandom), a, d, rd, ($urandom_range(0, 3) == 0),
                 $urandom, ($urandom_range(0, 4) == 0));
        end
      endcase
      if ($urandom_range(0, 1) == 1) tick();
    end
  endtask

  task automatic check_outputs_zero(input string tag);
    chk({tag, "_prdata"}, prdata, '0);
    chk({tag, "_pready"}, 32'(pready), '0);
    chk({tag, "_pslverr"}, 32'(pslverr), '0);
    chk({tag, "_cmdout"}, cmdout, '0);
    chk({tag, "_cmdvalid"}, 32'(cmdvalid), '0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, %0d/%0d", n_pass, n_chk);
    $fatal(1);
  end

  initial begin
    logic [31:0] rd;
    rst_n = 0; psel = 0; penable = 0; pwrite = 0; paddr = '0; pwdata = '0;
    cmd_accept = 0; result_valid = 0; result_in = '0;
    model_reset();
    repeat (2) @(posedge clk);
    #1;
    check_outputs_zero("reset");
    rst_n = 1;
    cv_base = cv_pulses;
    tick();

    // One wait state
    do_apb("cmd_wr", 1, 4'h0, 32'h4800_0000, rd);
    chk("cmd_wr_out", cmdout, 32'h4800_0000);
    @(negedge clk); chk("cmdvalid_hi", 32'(cmdvalid), 32'd1);
    tick();
    @(negedge clk); chk("cmdvalid_lo", 32'(cmdvalid), 32'd0);
    tick();
    do_apb("st_pend", 0, 4'h4, 0, rd); chk("st_pend_val", rd, 32'h2);

    do_apb("cmd_busy", 1, 4'h0, 32'h1111_0000, rd);
    chk("cmd_busy_out", cmdout, 32'h4800_0000);
    pulse_accept();
    do_apb("st_acc", 0, 4'h4, 0, rd); chk("st_acc_val", rd, 32'h0);

    do_apb("cmd_wr2", 1, 4'h0, 32'h0000_0055, rd);
    do_apb("cmd_race", 1, 4'h0, 32'h0000_0066, rd, 0, 0, 1);
    chk("cmd_race_out", cmdout, 32'h0000_0055);
    do_apb("st_race", 0, 4'h4, 0, rd); chk("st_race_val", rd, 32'h0);

    pulse_rv(32'h1234_2001);
    do_apb("st_rdy", 0, 4'h4, 0, rd); chk("st_rdy_val", rd, 32'h1);
    do_apb("res_rd", 0, 4'h8, 0, rd); chk("res_rd_val", rd, 32'h1234_2001);
    do_apb("st_clr", 0, 4'h4, 0, rd); chk("st_clr_val", rd, 32'h0);

    pulse_rv(32'hAAAA_0001);
    tick();
    pulse_rv(32'hBBBB_0001);
    do_apb("st_ovr", 0, 4'h4, 0, rd); chk("st_ovr_val", rd, 32'h5);
    do_apb("ctrl_ovr", 1, 4'hC, 32'h1, rd);
    do_apb("st_ovrc", 0, 4'h4, 0, rd); chk("st_ovrc_val", rd, 32'h1);
    do_apb("res_2nd", 0, 4'h8, 0, rd); chk("res_2nd_val", rd, 32'hBBBB_0001);

    pulse_rv(32'hCCCC_0001);
    do_apb("res_co", 0, 4'h8, 0, rd, 1, 32'hDDDD_0001); chk("res_co_val", rd, 32'hCCCC_0001);
    do_apb("st_co", 0, 4'h4, 0, rd); chk("st_co_val", rd, 32'h1);
    do_apb("res_new", 0, 4'h8, 0, rd); chk("res_new_val", rd, 32'hDDDD_0001);

    pulse_rv(32'hEEEE_0001);
    pulse_rv(32'hEEEE_0002);
    do_apb("ctrl_race", 1, 4'hC, 32'h1, rd, 1, 32'hFFFF_0001);
    do_apb("st_setwin", 0, 4'h4, 0, rd); chk("st_setwin_val", rd, 32'h5);

    do_apb("cmd_wr3", 1, 4'h0, 32'h0000_0077, rd);
    do_apb("soft", 1, 4'hC, 32'h2, rd, 1, 32'h9999_9999);
    chk("soft_cmdout", cmdout, 32'h0);
    do_apb("st_soft", 0, 4'h4, 0, rd); chk("st_soft_val", rd, 32'h0);
    do_apb("res_soft", 0, 4'h8, 0, rd); chk("res_soft_val", rd, 32'h0);

    do_apb("err_wst", 1, 4'h4, 32'hFFFF_FFFF, rd);
    do_apb("err_mis", 0, 4'h2, 0, rd);
    do_apb("err_cmd", 1, 4'h0, 32'hC000_0000, rd);
    do_apb("err_rctl", 0, 4'hC, 0, rd);
    do_apb("st_err", 0, 4'h4, 0, rd); chk("st_err_val", rd, 32'h0);

    // Abort: PSEL dropped before PREADY
    psel = 1; penable = 0; pwrite = 1; paddr = 4'h0; pwdata = 32'h0000_0099;
    tick();
    penable = 1;
    @(negedge clk); chk("abort_pready", 32'(pready), 32'd0);
    tick();
    psel = 0; penable = 0;
    tick();
    tick();
    chk("abort_cmdout", cmdout, 32'h0);
    do_apb("st_abort", 0, 4'h4, 0, rd); chk("st_abort_val", rd, 32'h0);

    random_ops(60);
    chk("w1_cmdvalid_pulses", 32'(cv_pulses - cv_base), 32'(m_writes));

    // Zero wait states
    wsel = 0;
    rst_n = 0;
    tick();
    rst_n = 1;
    model_reset();
    cv_base = cv_pulses;
    tick();
    do_apb("b2b_w", 1, 4'h0, 32'h0000_1234, rd);
    do_apb("b2b_s", 0, 4'h4, 0, rd); chk("b2b_s_val", rd, 32'h2);
    do_apb("b2b_c", 0, 4'h0, 0, rd); chk("b2b_c_val", rd, 32'h0000_1234);
    do_apb("b2b_e", 1, 4'h8, 32'h1, rd);
    tick();
    random_ops(60);
    tick();
    chk("w0_cmdvalid_pulses", 32'(cv_pulses - cv_base), 32'(m_writes));

    // Reset during ACCESS
    tick();
    psel = 1; penable = 0; pwrite = 1; paddr = 4'h0; pwdata = 32'h0000_0077;
    tick();
    penable = 1;
    #2 rst_n = 0;
    #1 check_outputs_zero("rst_mid");
    psel = 0; penable = 0;
    tick();
    rst_n = 1;
    model_reset();
    tick();
    do_apb("post_rst_st", 0, 4'h4, 0, rd); chk("post_rst_st_val", rd, 32'h0);
    do_apb("post_rst_w", 1, 4'h0, 32'h0000_0042, rd);
    do_apb("post_rst_st2", 0, 4'h4, 0, rd); chk("post_rst_st2_val", rd, 32'h2);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
